// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: counter clear, timed/open-ended operate window, drain, done.
// Optional per-run record limit enabled by defining RECORD_LIMIT_EN.
module acq_sequencer #(
    parameter int unsigned DUR_W        = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned CLR_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic             stop_req,
    input  logic [DUR_W-1:0] duration,
`ifdef RECORD_LIMIT_EN
    input  logic [CNT_W-1:0] record_limit,
`endif
    input  logic             data_rdy,
    output logic             operate,
    output logic             reset_counter,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] record_count,
    output logic             count_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned PH_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  CLR_LAST   = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_nx;
    logic [PH_W-1:0]  phase, phase_nx;
    logic [DUR_W-1:0] dur_reg, dur_nx;
    logic [DUR_W-1:0] run_cnt, run_cnt_nx;
    logic [CNT_W-1:0] count_nx;
    logic             sat_nx;
    logic             operate_nx, reset_counter_nx, busy_nx, done_nx;
    logic             counting, run_end, limit_hit;

`ifdef RECORD_LIMIT_EN
    logic [CNT_W-1:0] limit_reg, limit_nx;
`endif

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        dur_nx     = dur_reg;
        run_cnt_nx = run_cnt;
        count_nx   = record_count;
        sat_nx     = count_sat;
        limit_hit  = 1'b0;
`ifdef RECORD_LIMIT_EN
        limit_nx   = limit_reg;
`endif

        counting = ((state == S_RUN) || (state == S_DRAIN)) && data_rdy;
        if (counting) begin
            if (record_count != CNT_MAX) begin
                count_nx = record_count + CNT_W'(1);
            end
            if (count_nx == CNT_MAX) begin
                sat_nx = 1'b1;
            end
        end

`ifdef RECORD_LIMIT_EN
        limit_hit = (state == S_RUN) && counting && (limit_reg != '0) && (count_nx == limit_reg);
`endif

        // run_cnt counts completed RUN cycles; the window closes after dur_reg of them
        run_end = (dur_reg != '0) && (run_cnt == dur_reg - DUR_W'(1));

        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nx = S_CLEAR;
                    phase_nx = '0;
                    dur_nx   = duration;
                    count_nx = '0;
                    sat_nx   = 1'b0;
`ifdef RECORD_LIMIT_EN
                    limit_nx = record_limit;
`endif
                end
            end
            S_CLEAR: begin
                if (stop_req) begin
                    state_nx = S_DRAIN;
                    phase_nx = '0;
                end else if (phase == CLR_LAST) begin
                    state_nx   = S_RUN;
                    run_cnt_nx = '0;
                end else begin
                    phase_nx = phase + PH_W'(1);
                end
            end
            S_RUN: begin
                if (stop_req || run_end || limit_hit) begin
                    state_nx = S_DRAIN;
                    phase_nx = '0;
                end else begin
                    run_cnt_nx = run_cnt + DUR_W'(1);
                end
            end
            S_DRAIN: begin
                if (phase == DRAIN_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    phase_nx = phase + PH_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        operate_nx       = (state_nx == S_RUN);
        reset_counter_nx = (state_nx == S_CLEAR);
        busy_nx          = (state_nx != S_IDLE);
        // done is issued on the edge that leaves DONE, together with busy falling
        done_nx          = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            phase         <= '0;
            dur_reg       <= '0;
            run_cnt       <= '0;
            operate       <= 1'b0;
            reset_counter <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            record_count  <= '0;
            count_sat     <= 1'b0;
`ifdef RECORD_LIMIT_EN
            limit_reg     <= '0;
`endif
        end else begin
            state         <= state_nx;
            phase         <= phase_nx;
            dur_reg       <= dur_nx;
            run_cnt       <= run_cnt_nx;
            operate       <= operate_nx;
            reset_counter <= reset_counter_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            record_count  <= count_nx;
            count_sat     <= sat_nx;
`ifdef RECORD_LIMIT_EN
            limit_reg     <= limit_nx;
`endif
        end
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Run controller for the photon time-tagger datapath: sequences one acquisition per host start command.
- Pulses `reset_counter` to clear the timestamp counter, then holds `operate` high for a programmed duration or until stopped.
- After `operate` drops, waits for the click-latch/record pipeline to drain, then signals completion.
- Counts emitted records (`data_rdy`) per run for host bookkeeping; sits between host control registers and the timer/latch datapath.

Parameters:
- DUR_W, 32, width of run-duration register (clk cycles)
- CNT_W, 32, width of per-run record counter
- CLR_CYCLES, 4, cycles `reset_counter` is held high before `operate` rises (>=1)
- DRAIN_CYCLES, 8, cycles after `operate` falls during which records are still counted (>=1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_req  in  1  one-cycle pulse: begin a run (ignored while busy)
- stop_req  in  1  one-cycle pulse: end the current run early
- duration  in  DUR_W  run length in clk cycles, sampled on accepted start_req; 0 = run until stop_req
- data_rdy  in  1  record strobe from the timer datapath
- operate  out  1  enables detector latches and timer
- reset_counter  out  1  clears the timer timestamp counter
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run
- record_count  out  CNT_W  records seen in the current/last run
- count_sat  out  1  sticky: record_count saturated this run

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE; operate, reset_counter, busy, done, count_sat = 0; record_count = 0.
  - Mid-run reset drops `operate`/`reset_counter` on the same edge; no done pulse is issued.
- All outputs are registered.
- IDLE:
  - start_req=1 → next edge: state=CLEAR, busy=1, reset_counter=1, dur_reg<=duration, record_count<=0, count_sat<=0.
  - stop_req alone in IDLE is ignored. start_req and stop_req together in IDLE: start is accepted and stop is ignored.
- CLEAR:
  - reset_counter high for exactly CLR_CYCLES cycles, operate=0.
  - Then → RUN: reset_counter=0 and operate=1 on the same edge.
  - stop_req during CLEAR → DRAIN next edge; operate never rises; reset_counter drops.
- RUN:
  - operate=1. If dur_reg≠0, operate stays high for exactly dur_reg cycles, then RUN → DRAIN with operate=0.
  - stop_req → DRAIN next edge (operate low from that edge).
  - If stop_req coincides with the final duration cycle, the transition is identical: no extra cycle.
  - dur_reg=0: RUN persists until stop_req.
- DRAIN: operate=0 for DRAIN_CYCLES cycles, then → DONE.
- DONE: done=1 for one cycle, busy=0 on the same edge, state → IDLE. A start_req during the DONE cycle is ignored.
- start_req while busy (CLEAR/RUN/DRAIN/DONE) is ignored, with no side effects.
- Record counting:
  - record_count increments on each data_rdy sampled while state is RUN or DRAIN. data_rdy in IDLE/CLEAR/DONE is ignored.
  - At the all-ones value it holds and count_sat<=1. count_sat stays set until the next accepted start.
- record_count and count_sat hold their values after done, until the next accepted start or reset.
- Latency:
  - start_req → operate rise: CLR_CYCLES+1 edges.
  - stop_req → operate fall: 1 edge.
  - operate fall → done: DRAIN_CYCLES+1 edges.

Optional Feature:
- RECORD_LIMIT_EN defined:
  - Adds input `record_limit` [CNT_W-1:0], sampled with duration on an accepted start; 0 = no limit.
  - In RUN, when the incremented record_count equals record_limit, state → DRAIN on that edge, exactly as for stop_req.
  - Records arriving in DRAIN are still counted, so the final count may exceed the limit.
- Undefined: the port is absent and there is no limit logic.

Test Plan:
- Normal run (CLR_CYCLES=4, DRAIN_CYCLES=8):
  - start_req, duration=100 → reset_counter high 4 cycles; operate high exactly 100 cycles; done pulse 9 cycles after operate falls; busy low with done.
- Counting:
  - 5 data_rdy pulses during RUN and 2 during DRAIN, 3 in IDLE → record_count=7, count_sat=0.
- Early stop / open-ended run:
  - duration=0, stop_req 50 cycles after operate rises → operate high 50 cycles, falls next edge.
  - stop_req during CLEAR → operate never asserts; done still pulses after the DRAIN period.
- Ignored commands and saturation:
  - start_req during RUN → no restart, dur_reg unchanged.
  - CNT_W=4, 20 data_rdy in RUN → record_count=15, count_sat=1.
  - Next start → both cleared.
- Reset mid-run: reset asserted in RUN → next edge operate=0, busy=0, record_count=0, no done; a subsequent start works normally.
- RECORD_LIMIT_EN, record_limit=3, duration=0: third data_rdy in RUN → DRAIN next edge, operate low; 1 record in DRAIN → final record_count=4.
